// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared game constants: motion state encoding, sprite, block
//               and screen sizes, and collision flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } motion_state_t;

  localparam int SPRITE_W = 47;
  localparam int SPRITE_H = 41;
  localparam int BLOCK_W  = 25;
  localparam int BLOCK_H  = 24;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int COL_DOWN  = 0;
  localparam int COL_UP    = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

endpackage
`default_nettype wire

// File: rtl/jump_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : jump_req_latch
// Description : Detects rising edges of the jump button and holds a jump
//               request until the next frame tick. An edge arriving on the
//               tick cycle itself is passed straight through so that tick
//               can act on it.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_req_latch (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_jump,
  output logic jump_req
);

  logic r_btn_prev;
  logic r_req;
  logic w_edge;

  assign w_edge   = btn_jump & ~r_btn_prev;
  assign jump_req = r_req | w_edge;

  // Edge history and request register; every tick consumes the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_prev <= 1'b0;
      r_req      <= 1'b0;
    end else begin
      r_btn_prev <= btn_jump;
      if (tick) begin
        r_req <= 1'b0;
      end else if (w_edge) begin
        r_req <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module      : player_motion
// Description : Per-frame motion controller for the blue player sprite.
//               Grounded/rising/falling state machine with gravity, walking,
//               screen clamps and collision response. Updates once per tick.
//               Optional mid-air second jump when PLAYER_DOUBLE_JUMP_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion
  import game_pkg::*;
#(
  parameter logic [9:0] X_INIT    = 10'd40,
  parameter logic [8:0] Y_INIT    = 9'd100,
  parameter int         WALK_STEP = 3,
  parameter int         JUMP_V    = 12,
  parameter int         GRAVITY   = 1,
  parameter int         VMAX      = 8,
  parameter logic [9:0] X_MAX     = 10'(SCREEN_W - SPRITE_W),
  parameter logic [8:0] Y_MAX     = 9'(SCREEN_H - SPRITE_H)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [3:0] is_Collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] state,
  output logic       on_ground
);

  localparam logic [9:0]         c_walk    = 10'(WALK_STEP);
  localparam logic signed [5:0]  c_gravity = 6'(GRAVITY);
  localparam logic signed [5:0]  c_vmax    = 6'(VMAX);
  localparam logic signed [5:0]  c_vy_jump = 6'(-JUMP_V);
  localparam logic signed [10:0] c_y_max_s = $signed({2'b00, Y_MAX});

  motion_state_t      r_state, w_state_nxt;
  logic [9:0]         r_x, w_x_nxt;
  logic [8:0]         r_y, w_y_nxt;
  logic signed [5:0]  r_vy, w_vy_nxt;
  logic               r_on_ground;

  logic               w_jump;
  logic [10:0]        w_x_right;
  logic signed [10:0] w_y_sum;
  logic signed [5:0]  w_vy_inc;

  jump_req_latch u_jump_req_latch (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn_jump (btn_jump),
    .jump_req (w_jump)
  );

  assign w_x_right = {1'b0, r_x} + 11'(WALK_STEP);
  assign w_y_sum   = $signed({2'b00, r_y}) + $signed({{5{r_vy[5]}}, r_vy});
  assign w_vy_inc  = r_vy + c_gravity;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic r_air_jump, w_air_nxt;
  logic w_air_ok;

  // Airborne with no head hit, no top clamp and no landing on this tick.
  assign w_air_ok = tick &&
                    (((r_state == RISING)  && !is_Collision[COL_UP] && !w_y_sum[10]) ||
                     ((r_state == FALLING) && !is_Collision[COL_DOWN] && (w_y_sum < c_y_max_s)));
`endif

  // Next-state, position and velocity; everything holds unless tick is high.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vy_nxt    = r_vy;
`ifdef PLAYER_DOUBLE_JUMP_EN
    w_air_nxt   = r_air_jump;
`endif
    if (tick) begin
      // Horizontal: one direction only, unless blocked on that side.
      if (btn_left && !btn_right && !is_Collision[COL_LEFT]) begin
        w_x_nxt = (r_x < c_walk) ? 10'd0 : (r_x - c_walk);
      end else if (btn_right && !btn_left && !is_Collision[COL_RIGHT]) begin
        w_x_nxt = (w_x_right > {1'b0, X_MAX}) ? X_MAX : w_x_right[9:0];
      end

      // Vertical.
      case (r_state)
        GROUNDED: begin
          if (!is_Collision[COL_DOWN] && (r_y < Y_MAX)) begin
            w_state_nxt = FALLING;
            w_vy_nxt    = 6'sd0;
          end else if (w_jump) begin
            w_state_nxt = RISING;
            w_vy_nxt    = c_vy_jump;
          end
        end
        RISING: begin
          if (is_Collision[COL_UP]) begin
            w_state_nxt = FALLING;
            w_vy_nxt    = 6'sd0;
          end else if (w_y_sum[10]) begin
            w_y_nxt     = 9'd0;
            w_state_nxt = FALLING;
            w_vy_nxt    = 6'sd0;
          end else begin
            w_y_nxt  = w_y_sum[8:0];
            w_vy_nxt = w_vy_inc;
            if (!w_vy_inc[5]) begin
              w_state_nxt = FALLING;
            end
          end
        end
        FALLING: begin
          if (is_Collision[COL_DOWN]) begin
            w_state_nxt = GROUNDED;
            w_vy_nxt    = 6'sd0;
          end else if (w_y_sum >= c_y_max_s) begin
            w_y_nxt     = Y_MAX;
            w_state_nxt = GROUNDED;
            w_vy_nxt    = 6'sd0;
          end else begin
            w_y_nxt  = w_y_sum[8:0];
            w_vy_nxt = (w_vy_inc > c_vmax) ? c_vmax : w_vy_inc;
          end
        end
        default: begin
          // Unused encoding: drop into free fall from where we are.
          w_state_nxt = FALLING;
          w_vy_nxt    = 6'sd0;
        end
      endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
      // Second jump reuses the position already advanced by the old velocity.
      if (w_air_ok && w_jump && r_air_jump) begin
        w_state_nxt = RISING;
        w_vy_nxt    = c_vy_jump;
        w_air_nxt   = 1'b0;
      end
      if (w_state_nxt == GROUNDED) begin
        w_air_nxt = 1'b1;
      end
`endif
    end
  end

  // State, position and velocity registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FALLING;
      r_x         <= X_INIT;
      r_y         <= Y_INIT;
      r_vy        <= 6'sd0;
      r_on_ground <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_vy        <= w_vy_nxt;
      r_on_ground <= (w_state_nxt == GROUNDED);
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  // Air-jump credit, refilled on every landing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_air_jump <= 1'b0;
    end else begin
      r_air_jump <= w_air_nxt;
    end
  end
`endif

  assign x_blue    = r_x;
  assign y_blue    = r_y;
  assign state     = r_state;
  assign on_ground = r_on_ground;

endmodule
`default_nettype wire
